// File: rtl/sseg_pkg.sv
// Shared types for the seven-segment display arbiter: FSM states, digit packing
// and client indexing.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;
  typedef digit_t [3:0] digits_t;
  typedef logic client_t;

  localparam int HOLD_W = 16;

  // Ownership state that corresponds to a given client index.
  function automatic state_t own_state(client_t c);
    return c ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sseg_hold_timer.sv
// Saturating ownership timer: counts owned cycles and flags when a contested
// grant is allowed to move.
module sseg_hold_timer
  import sseg_pkg::*;
#(
  parameter int HOLD_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count;

  // Clear wins over enable; the count parks at LAST so a long uncontested
  // ownership lets a later contender switch on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + HOLD_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/sseg_arb.sv
// Two-client arbiter for a shared four-digit seven-segment display with a
// minimum hold time under contention and registered, grant-aligned digits.
module sseg_arb
  import sseg_pkg::*;
#(
  parameter int HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] c0_digits,
  input  logic [15:0] c1_digits,
  output logic [1:0]  grant,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        blank
);

  state_t  state;
  state_t  next_state;
  client_t last_grant;
  digits_t digits_q;
  logic    hold_expired;
  logic    hold_clear;
  logic    hold_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An owner that drops its request releases at once; a still-requesting owner
  // only yields to a contender once the hold timer has expired.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (req == 2'b11) begin
          next_state = own_state(~last_grant);
        end else if (req[0]) begin
          next_state = OWN0;
        end else if (req[1]) begin
          next_state = OWN1;
        end else begin
          next_state = IDLE;
        end
      end
      OWN0: begin
        if (!req[0]) begin
          next_state = req[1] ? OWN1 : IDLE;
        end else if (req[1] && hold_expired) begin
          next_state = OWN1;
        end
      end
      OWN1: begin
        if (!req[1]) begin
          next_state = req[0] ? OWN0 : IDLE;
        end else if (req[0] && hold_expired) begin
          next_state = OWN0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    blank = 1'b1;
    unique case (state)
      OWN0: begin
        grant = 2'b01;
        blank = 1'b0;
      end
      OWN1: begin
        grant = 2'b10;
        blank = 1'b0;
      end
      default: begin
        grant = 2'b00;
        blank = 1'b1;
      end
    endcase
  end

  assign hold_clear  = (next_state != state) || (state == IDLE);
  assign hold_enable = (state != IDLE);

  sseg_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (hold_clear),
    .enable (hold_enable),
    .expired(hold_expired)
  );

  // Reset value 1 makes client 0 the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (next_state == OWN0) begin
      last_grant <= 1'b0;
    end else if (next_state == OWN1) begin
      last_grant <= 1'b1;
    end
  end

  // Digits are selected by the upcoming state so they change on the same edge
  // as grant and never mix clients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      unique case (next_state)
        OWN0:    digits_q <= c0_digits;
        OWN1:    digits_q <= c1_digits;
        default: digits_q <= '0;
      endcase
    end
  end

  assign digit0 = digits_q[0];
  assign digit1 = digits_q[1];
  assign digit2 = digits_q[2];
  assign digit3 = digits_q[3];

endmodule

// File: tb/tb_sseg_arb.sv
// Directed self-checking bench for sseg_arb with HOLD_CYCLES=8, plus per-cycle
// invariant checks on grant, blank and digit ownership.
module tb_sseg_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] c0_digits;
  logic [15:0] c1_digits;
  logic [1:0]  grant;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        blank;

  logic [15:0] digits_out;
  logic [15:0] c0_sampled;
  logic [15:0] c1_sampled;
  logic [15:0] owner_expected;
  int          checks;
  int          failures;

  sseg_arb #(
    .HOLD_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .c0_digits(c0_digits),
    .c1_digits(c1_digits),
    .grant    (grant),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .blank    (blank)
  );

  assign digits_out = {digit3, digit2, digit1, digit0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] d0,
                               input logic [15:0] d1);
    req       = r;
    c0_digits = d0;
    c1_digits = d1;
  endtask

  task automatic wait_negedges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs only change at negedges, so this captures exactly what the DUT
  // registered on the same rising edge.
  always @(posedge clk) begin
    c0_sampled = c0_digits;
    c1_sampled = c1_digits;
  end

  // Invariants checked every cycle: grant never 11, blank mirrors an idle
  // grant, and digits belong to the current owner (zero when idle).
  always @(negedge clk) begin
    if (grant == 2'b01) begin
      owner_expected = c0_sampled;
    end else if (grant == 2'b10) begin
      owner_expected = c1_sampled;
    end else begin
      owner_expected = 16'h0000;
    end
    checkOutput("grant_onehot", 32'(grant == 2'b11), 32'd0);
    checkOutput("blank_vs_grant", 32'(blank), 32'(grant == 2'b00));
    checkOutput("owner_digits", 32'(digits_out), 32'(owner_expected));
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(2'b00, 16'h3210, 16'h7654);
    wait_negedges(2);
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_blank", 32'(blank), 32'h1);
    checkOutput("reset_digits", 32'(digits_out), 32'h0);
    rst_n = 1'b1;

    // Single owner, held indefinitely without contention
    applyStimulus(2'b01, 16'h3210, 16'h7654);
    wait_negedges(1);
    checkOutput("single_grant", 32'(grant), 32'h1);
    checkOutput("single_blank", 32'(blank), 32'h0);
    checkOutput("single_digits", 32'(digits_out), 32'h3210);
    wait_negedges(12);
    checkOutput("single_held", 32'(grant), 32'h1);
    applyStimulus(2'b01, 16'h9999, 16'h7654);
    wait_negedges(1);
    checkOutput("single_digit_update", 32'(digits_out), 32'h9999);

    applyStimulus(2'b00, 16'h3210, 16'h7654);
    wait_negedges(1);
    checkOutput("release_idle_grant", 32'(grant), 32'h0);
    checkOutput("release_idle_digits", 32'(digits_out), 32'h0);

    // Asynchronous reset while client 0 owns the display
    applyStimulus(2'b01, 16'h3210, 16'h7654);
    wait_negedges(1);
    checkOutput("pre_reset_grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_grant", 32'(grant), 32'h0);
    checkOutput("async_reset_blank", 32'(blank), 32'h1);
    checkOutput("async_reset_digits", 32'(digits_out), 32'h0);
    wait_negedges(1);
    rst_n = 1'b1;
    wait_negedges(1);
    checkOutput("post_reset_grant", 32'(grant), 32'h1);

    // Tie straight out of reset: client 0 first, then alternate every 8 cycles
    #2 rst_n = 1'b0;
    wait_negedges(1);
    applyStimulus(2'b11, 16'h3210, 16'h7654);
    rst_n = 1'b1;
    wait_negedges(1);
    checkOutput("tie_first_grant", 32'(grant), 32'h1);
    checkOutput("tie_first_digits", 32'(digits_out), 32'h3210);
    wait_negedges(7);
    checkOutput("tie_cycle8_grant", 32'(grant), 32'h1);
    wait_negedges(1);
    checkOutput("tie_switch_grant", 32'(grant), 32'h2);
    checkOutput("tie_switch_digits", 32'(digits_out), 32'h7654);
    wait_negedges(7);
    checkOutput("tie_c1_cycle8_grant", 32'(grant), 32'h2);
    wait_negedges(1);
    checkOutput("tie_switch_back_grant", 32'(grant), 32'h1);

    // Contender arrives at owned cycle 2; owner keeps the display through cycle 8
    applyStimulus(2'b00, 16'hABCD, 16'h1357);
    wait_negedges(1);
    checkOutput("hold_idle_grant", 32'(grant), 32'h0);
    applyStimulus(2'b01, 16'hABCD, 16'h1357);
    wait_negedges(1);
    checkOutput("hold_cycle1_grant", 32'(grant), 32'h1);
    wait_negedges(1);
    applyStimulus(2'b11, 16'hABCD, 16'h1357);
    for (int k = 3; k <= 8; k++) begin
      wait_negedges(1);
      checkOutput($sformatf("hold_cycle%0d_grant", k), 32'(grant), 32'h1);
    end
    wait_negedges(1);
    checkOutput("hold_switch_grant", 32'(grant), 32'h2);
    checkOutput("hold_switch_digits", 32'(digits_out), 32'h1357);

    // Early release at owned cycle 3 with the other client waiting
    applyStimulus(2'b00, 16'hABCD, 16'h1357);
    wait_negedges(1);
    applyStimulus(2'b11, 16'hABCD, 16'h1357);
    wait_negedges(1);
    checkOutput("early_tie_grant", 32'(grant), 32'h1);
    wait_negedges(2);
    applyStimulus(2'b10, 16'hABCD, 16'h1357);
    wait_negedges(1);
    checkOutput("early_handover_grant", 32'(grant), 32'h2);
    checkOutput("early_handover_digits", 32'(digits_out), 32'h1357);

    // Owner 1 drops while client 0 requests, then client 0 releases alone
    applyStimulus(2'b01, 16'h2468, 16'h1357);
    wait_negedges(1);
    checkOutput("release_to_c0_grant", 32'(grant), 32'h1);
    checkOutput("release_to_c0_digits", 32'(digits_out), 32'h2468);
    wait_negedges(2);
    applyStimulus(2'b00, 16'h2468, 16'h1357);
    wait_negedges(1);
    checkOutput("early_idle_grant", 32'(grant), 32'h0);
    checkOutput("early_idle_blank", 32'(blank), 32'h1);
    checkOutput("early_idle_digits", 32'(digits_out), 32'h0);

    // Tie from idle after client 0 was last owner goes to client 1
    applyStimulus(2'b11, 16'h2468, 16'h1357);
    wait_negedges(1);
    checkOutput("tie_last0_grant", 32'(grant), 32'h2);
    checkOutput("tie_last0_digits", 32'(digits_out), 32'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sseg_arb.md
SSEG_ARB -- requirements
Module: sseg_arb

Interface
REQ-001 Parameter HOLD_CYCLES, default 256: minimum ownership cycles before a contested grant may move; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  2  per-client display request, level; bit i = client i.
REQ-005 c0_digits  input  16  client 0 digits: [3:0]=digit0 ... [15:12]=digit3.
REQ-006 c1_digits  input  16  client 1 digits, same packing.
REQ-007 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-008 digit0, digit1, digit2, digit3  output  4 each  digit values to the 7-seg driver.
REQ-009 blank  output  1  high when no client owns the display.

Function
REQ-010 FSM states IDLE, OWN0, OWN1; grant and blank decoded from registered state: IDLE->00/1, OWN0->01/0, OWN1->10/0.
REQ-011 IDLE: single requester i -> OWNi next edge; both requesting -> client not in last_grant wins; none -> stay IDLE.
REQ-012 OWNi, req[i] low -> OWNj next edge if req[j] high, else IDLE; release does not wait for hold expiry.
REQ-013 OWNi, req[i] high, req[j] low -> stay OWNi indefinitely.
REQ-014 OWNi, req[i] and req[j] high -> switch to OWNj only on the edge where hold_cnt == HOLD_CYCLES-1; otherwise stay.
REQ-015 hold_cnt: cleared on every state change and in IDLE; increments each cycle in OWNi; saturates at HOLD_CYCLES-1.
REQ-016 last_grant: 1-bit register, loaded with i on every entry into OWNi; unchanged in IDLE.
REQ-017 Digit outputs registered: on each edge, state OWNi in the next cycle -> load ci_digits; IDLE next -> load 0; data latency is one cycle, aligned with grant.
REQ-018 Switch cycle: the first cycle with new grant shows the new owner's digits; no cycle mixes clients.
REQ-019 grant never has both bits set; digits from a non-owner never reach the outputs.

Reset
REQ-020 rst_n low -> immediately: state IDLE, grant 2'b00, blank 1, digit0..3 4'h0, hold_cnt 0, last_grant 1 (client 0 wins first tie).
REQ-021 Reset mid-ownership discards the grant; after release, arbitration restarts per REQ-011 on the first rising edge with rst_n high.

Structure
REQ-022 Shared package sseg_pkg holds: state enum (IDLE, OWN0, OWN1), digit_t (4-bit), digits_t (4 x digit_t packed, 16 bits), client index typedef.
REQ-023 One sub-module sseg_hold_timer (clear, enable, saturating count, expired flag) parameterised by HOLD_CYCLES; FSM and output registers stay in sseg_arb.
REQ-024 Implementation is purely synchronous apart from the asynchronous reset; no latches; no combinational path from inputs to outputs.

Verification (HOLD_CYCLES=8)
REQ-025 Reset: rst_n low mid-simulation with req=2'b01 -> grant 00, blank 1, digits 0 within the same time step; after release, grant 01 one edge later.
REQ-026 Single owner: req=01, c0_digits=16'h3210 -> next edge grant=01, digit3..0=3,2,1,0, blank 0; held while req stays high.
REQ-027 Tie from IDLE after reset: req=11 -> grant 01; after 8 owned cycles grant 10 and digits equal c1_digits=16'h7654 in the same cycle.
REQ-028 Hold respected: owner 0 granted, req1 raised at owned cycle 2 -> grant stays 01 until owned cycle 8, then 10; no intermediate 00.
REQ-029 Early release: owner 0 drops req at owned cycle 3 with req1 high -> grant 10 next edge; with req1 low -> grant 00, blank 1, digits 0.
REQ-030 Assertions throughout all scenarios: grant one-hot-or-zero; blank == (grant==0); outputs equal the owner's digits delayed by one cycle.
